// File: rtl/jt49_pkg.sv
// Shared JT49 definitions: envelope register addresses and shape-bit positions.
package jt49_pkg;

  localparam logic [3:0] ENV_PER_LO = 4'd11;
  localparam logic [3:0] ENV_PER_HI = 4'd12;
  localparam logic [3:0] ENV_SHAPE  = 4'd13;

  // Positions inside ctrl = {CONT, ATT, ALT, HOLD}
  localparam int unsigned CTRL_HOLD = 0;
  localparam int unsigned CTRL_ALT  = 1;
  localparam int unsigned CTRL_ATT  = 2;
  localparam int unsigned CTRL_CONT = 3;

endpackage

// File: rtl/jt49_env_div_if.sv
// Register write bus into the envelope divider.
interface jt49_env_div_if;

  logic       wr;
  logic [3:0] addr;
  logic [7:0] din;

  modport master (output wr, output addr, output din);
  modport slave  (input  wr, input  addr, input  din);

endinterface

// File: rtl/jt49_env_cnt.sv
// Envelope prescaler, 16-bit period counter and step toggle.
module jt49_env_cnt #(
  parameter int unsigned PRESCALE = 8
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        cen,
  input  logic        clr,
  input  logic [15:0] period,
  output logic        step
);

  localparam int unsigned PW = $clog2(PRESCALE);

  logic [PW-1:0] presc_q, presc_d;
  logic [15:0]   cnt_q, cnt_d;
  logic          step_q, step_d;
  logic          tick;
  logic [16:0]   cnt_inc;

  always_comb begin
    presc_d = presc_q;
    cnt_d   = cnt_q;
    step_d  = step_q;
    tick    = cen && (presc_q == PW'(PRESCALE - 1));
    // 17 bits so that period 0xFFFF is reachable without wrapping
    cnt_inc = {1'b0, cnt_q} + 17'd1;
    if (clr) begin
      presc_d = '0;
      cnt_d   = '0;
      step_d  = 1'b0;
    end else begin
      if (cen) begin
        presc_d = presc_q + PW'(1);
      end
      if (tick && (period != 16'd0)) begin
        if (cnt_inc >= {1'b0, period}) begin
          cnt_d  = '0;
          step_d = ~step_q;
        end else begin
          cnt_d = cnt_inc[15:0];
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      presc_q <= '0;
      cnt_q   <= '0;
      step_q  <= 1'b0;
    end else begin
      presc_q <= presc_d;
      cnt_q   <= cnt_d;
      step_q  <= step_d;
    end
  end

  assign step = step_q;

endmodule

// File: rtl/jt49_env_div.sv
// Envelope period divider: decodes period/shape writes, issues the restart
// pulse and hands counting to jt49_env_cnt.
module jt49_env_div
  import jt49_pkg::*;
#(
  parameter int unsigned PRESCALE = 8
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          cen,
  jt49_env_div_if.slave bus,
  output logic          step,
  output logic          null_period,
  output logic          restart,
  output logic [3:0]    ctrl
);

  logic [15:0] period_q, period_d;
  logic [3:0]  ctrl_q, ctrl_d;
  logic        restart_q, restart_d;
  logic        null_q, null_d;

  always_comb begin
    period_d  = period_q;
    ctrl_d    = ctrl_q;
    restart_d = 1'b0;
    if (bus.wr) begin
      case (bus.addr)
        ENV_PER_LO: period_d[7:0]  = bus.din;
        ENV_PER_HI: period_d[15:8] = bus.din;
        ENV_SHAPE: begin
          ctrl_d[CTRL_HOLD] = bus.din[CTRL_HOLD];
          ctrl_d[CTRL_ALT]  = bus.din[CTRL_ALT];
          ctrl_d[CTRL_ATT]  = bus.din[CTRL_ATT];
          ctrl_d[CTRL_CONT] = bus.din[CTRL_CONT];
          restart_d         = 1'b1;
        end
        default: ;
      endcase
    end
    null_d = (period_d == 16'd0);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      period_q  <= '0;
      ctrl_q    <= '0;
      restart_q <= 1'b0;
      null_q    <= 1'b1;
    end else begin
      period_q  <= period_d;
      ctrl_q    <= ctrl_d;
      restart_q <= restart_d;
      null_q    <= null_d;
    end
  end

  // The registered restart doubles as the counter clear, so the clear lands
  // in the cycle after the shape write and a reset cancels it.
  jt49_env_cnt #(
    .PRESCALE (PRESCALE)
  ) u_cnt (
    .clk    (clk),
    .rst    (rst),
    .cen    (cen),
    .clr    (restart_q),
    .period (period_q),
    .step   (step)
  );

  assign null_period = null_q;
  assign restart     = restart_q;
  assign ctrl        = ctrl_q;

endmodule

// File: tb/tb_jt49_env_div.sv
// Self-checking bench for jt49_env_div: cycle model feeds an expected-output queue.
module tb_jt49_env_div;
  import jt49_pkg::*;

  localparam int unsigned PRESCALE = 8;

  typedef struct packed {
    logic        step;
    logic        nul;
    logic        restart;
    logic [3:0]  ctrl;
    logic [15:0] cnt;
  } obs_t;

  typedef struct {
    logic       c;
    logic       w;
    logic [3:0] a;
    logic [7:0] d;
    logic       r;
  } stim_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic cen = 1'b0;
  logic step, null_period, restart;
  logic [3:0] ctrl;

  jt49_env_div_if bus_if ();

  jt49_env_div #(
    .PRESCALE (PRESCALE)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .cen         (cen),
    .bus         (bus_if),
    .step        (step),
    .null_period (null_period),
    .restart     (restart),
    .ctrl        (ctrl)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  obs_t exp_q[$];

  // Behavioural model state
  int         m_period = 0;
  int         m_cnt = 0;
  int         m_presc = 0;
  logic       m_step = 1'b0;
  logic       m_restart = 1'b0;
  logic       m_null = 1'b1;
  logic [3:0] m_ctrl = 4'h0;

  function automatic obs_t obs();
    return {step, null_period, restart, ctrl, dut.u_cnt.cnt_q};
  endfunction

  // Apply one cycle of stimulus, advance the model, queue the expectation.
  task automatic drive(input stim_t s);
    cen = s.c;
    bus_if.wr = s.w;
    bus_if.addr = s.a;
    bus_if.din = s.d;
    rst = s.r;
    if (s.r) begin
      m_period = 0; m_cnt = 0; m_presc = 0; m_step = 1'b0;
      m_restart = 1'b0; m_null = 1'b1; m_ctrl = 4'h0;
    end else begin
      if (m_restart) begin
        m_presc = 0; m_cnt = 0; m_step = 1'b0;
      end else if (s.c) begin
        m_presc = (m_presc + 1) % PRESCALE;
        if (m_presc == 0 && m_period != 0) begin
          if (m_cnt + 1 >= m_period) begin
            m_cnt = 0;
            m_step = ~m_step;
          end else begin
            m_cnt = m_cnt + 1;
          end
        end
      end
      m_restart = 1'b0;
      if (s.w) begin
        if (s.a == 4'd11) m_period = (m_period & 'hFF00) | int'(s.d);
        if (s.a == 4'd12) m_period = (m_period & 'h00FF) | (int'(s.d) << 8);
        if (s.a == 4'd13) begin
          m_ctrl = s.d[3:0];
          m_restart = 1'b1;
        end
      end
      m_null = (m_period == 0);
    end
    exp_q.push_back({m_step, m_null, m_restart, m_ctrl, 16'(m_cnt)});
    @(posedge clk);
    #1;
  endtask

  function automatic stim_t mk(logic c, logic w, logic [3:0] a, logic [7:0] d, logic r);
    stim_t s;
    s.c = c; s.w = w; s.a = a; s.d = d; s.r = r;
    return s;
  endfunction

  task automatic test_reset();
    stim_t sq[$];
    obs_t e, got;
    sq.push_back(mk(1'b1, 1'b1, ENV_SHAPE, 8'hFF, 1'b1));
    sq.push_back(mk(1'b1, 1'b1, ENV_PER_LO, 8'h55, 1'b1));
    sq.push_back(mk(1'b0, 1'b0, 4'd0, 8'h00, 1'b1));
    foreach (sq[i]) begin
      drive(sq[i]);
      e = exp_q.pop_front();
      got = obs();
      checks++;
      if (got !== e) begin
        errors++;
        $display("FAIL reset[%0d]: got %h expected %h", i, got, e);
      end
    end
  endtask

  task automatic test_idle();
    obs_t e, got;
    for (int i = 0; i < 40; i++) begin
      drive(mk((i % 4) == 3, 1'b0, 4'd0, 8'h00, 1'b0));
      e = exp_q.pop_front();
      got = obs();
      checks++;
      if (got !== e || {step, null_period, restart, ctrl} !== 7'b0100000) begin
        errors++;
        $display("FAIL idle[%0d]: got %h expected %h", i, got, e);
      end
    end
  endtask

  task automatic test_period();
    stim_t sq[$];
    obs_t e, got;
    int cens = 0;
    int rises[$];
    logic prev = 1'b0;
    sq.push_back(mk(1'b0, 1'b0, 4'd0, 8'h00, 1'b1));
    sq.push_back(mk(1'b0, 1'b1, ENV_PER_LO, 8'h03, 1'b0));
    sq.push_back(mk(1'b0, 1'b1, ENV_PER_HI, 8'h00, 1'b0));
    for (int i = 0; i < 80; i++) sq.push_back(mk(1'b1, 1'b0, 4'd0, 8'h00, 1'b0));
    foreach (sq[i]) begin
      drive(sq[i]);
      if (sq[i].c) cens++;
      e = exp_q.pop_front();
      got = obs();
      checks++;
      if (got !== e) begin
        errors++;
        $display("FAIL period[%0d]: got %h expected %h", i, got, e);
      end
      if (step && !prev) rises.push_back(cens);
      prev = step;
    end
    checks++;
    if (rises.size() < 2) begin
      errors++;
      $display("FAIL period_rises: got %0d rising edges expected 2", rises.size());
    end else begin
      checks++;
      if (rises[0] != 24 || rises[1] != 72) begin
        errors++;
        $display("FAIL period_edges: got %0d,%0d expected 24,72", rises[0], rises[1]);
      end
    end
  endtask

  task automatic test_back_to_back();
    stim_t sq[$];
    obs_t e, got;
    int pulses = 0;
    for (int i = 0; i < 30; i++) sq.push_back(mk(1'b1, 1'b0, 4'd0, 8'h00, 1'b0));
    sq.push_back(mk(1'b1, 1'b1, ENV_SHAPE, 8'hFE, 1'b0));
    sq.push_back(mk(1'b1, 1'b1, ENV_SHAPE, 8'h0E, 1'b0));
    for (int i = 0; i < 20; i++) sq.push_back(mk(1'b1, 1'b0, 4'd0, 8'h00, 1'b0));
    foreach (sq[i]) begin
      drive(sq[i]);
      e = exp_q.pop_front();
      got = obs();
      checks++;
      if (got !== e) begin
        errors++;
        $display("FAIL b2b[%0d]: got %h expected %h", i, got, e);
      end
      if (restart) pulses++;
    end
    checks++;
    if (pulses != 2 || ctrl !== 4'hE) begin
      errors++;
      $display("FAIL b2b_pulses: got %0d pulses ctrl %h expected 2 pulses ctrl e", pulses, ctrl);
    end
  endtask

  task automatic test_lower_period();
    stim_t sq[$];
    obs_t e, got;
    int n;
    sq.push_back(mk(1'b0, 1'b0, 4'd0, 8'h00, 1'b1));
    sq.push_back(mk(1'b0, 1'b1, ENV_PER_LO, 8'h00, 1'b0));
    sq.push_back(mk(1'b0, 1'b1, ENV_PER_HI, 8'h01, 1'b0));
    foreach (sq[i]) begin
      drive(sq[i]);
      e = exp_q.pop_front();
      got = obs();
      checks++;
      if (got !== e) begin
        errors++;
        $display("FAIL lower_setup[%0d]: got %h expected %h", i, got, e);
      end
    end
    n = 0;
    while (!(m_cnt == 'h80 && m_presc == 0) && n < 1100) begin
      drive(mk(1'b1, 1'b0, 4'd0, 8'h00, 1'b0));
      void'(exp_q.pop_front());
      n++;
    end
    checks++;
    if (dut.u_cnt.cnt_q !== 16'h0080) begin
      errors++;
      $display("FAIL lower_reach: got cnt %h expected 0080", dut.u_cnt.cnt_q);
    end
    sq.delete();
    sq.push_back(mk(1'b1, 1'b1, ENV_PER_LO, 8'h10, 1'b0));
    sq.push_back(mk(1'b1, 1'b1, ENV_PER_HI, 8'h00, 1'b0));
    for (int i = 0; i < 300; i++) sq.push_back(mk(1'b1, 1'b0, 4'd0, 8'h00, 1'b0));
    foreach (sq[i]) begin
      drive(sq[i]);
      e = exp_q.pop_front();
      got = obs();
      checks++;
      if (got !== e) begin
        errors++;
        $display("FAIL lower[%0d]: got %h expected %h", i, got, e);
      end
    end
  endtask

  task automatic test_max_period();
    stim_t sq[$];
    obs_t e, got;
    int toggles = 0;
    logic prev;
    logic frozen;
    sq.push_back(mk(1'b0, 1'b0, 4'd0, 8'h00, 1'b1));
    sq.push_back(mk(1'b0, 1'b1, ENV_PER_LO, 8'hFF, 1'b0));
    sq.push_back(mk(1'b0, 1'b1, ENV_PER_HI, 8'hFF, 1'b0));
    foreach (sq[i]) begin
      drive(sq[i]);
      e = exp_q.pop_front();
      got = obs();
      checks++;
      if (got !== e) begin
        errors++;
        $display("FAIL max_setup[%0d]: got %h expected %h", i, got, e);
      end
    end
    force dut.u_cnt.cnt_q = 16'hFFFD;
    #1;
    release dut.u_cnt.cnt_q;
    m_cnt = 'hFFFD;
    prev = step;
    for (int i = 0; i < 4 * PRESCALE; i++) begin
      drive(mk(1'b1, 1'b0, 4'd0, 8'h00, 1'b0));
      e = exp_q.pop_front();
      got = obs();
      checks++;
      if (got !== e) begin
        errors++;
        $display("FAIL max_wrap[%0d]: got %h expected %h", i, got, e);
      end
      if (step !== prev) toggles++;
      prev = step;
    end
    checks++;
    if (toggles != 1) begin
      errors++;
      $display("FAIL max_toggles: got %0d expected 1", toggles);
    end
    sq.delete();
    sq.push_back(mk(1'b1, 1'b1, ENV_PER_LO, 8'h00, 1'b0));
    sq.push_back(mk(1'b1, 1'b1, ENV_PER_HI, 8'h00, 1'b0));
    for (int i = 0; i < 40; i++) sq.push_back(mk(1'b1, 1'b0, 4'd0, 8'h00, 1'b0));
    frozen = step;
    foreach (sq[i]) begin
      drive(sq[i]);
      e = exp_q.pop_front();
      got = obs();
      checks++;
      if (got !== e || (i >= 1 && (null_period !== 1'b1 || step !== frozen))) begin
        errors++;
        $display("FAIL zero_period[%0d]: got %h expected %h", i, got, e);
      end
    end
  endtask

  task automatic test_reset_mid();
    stim_t sq[$];
    obs_t e, got;
    sq.push_back(mk(1'b0, 1'b1, ENV_PER_LO, 8'h02, 1'b0));
    for (int i = 0; i < 45; i++) sq.push_back(mk(1'b1, 1'b0, 4'd0, 8'h00, 1'b0));
    sq.push_back(mk(1'b1, 1'b1, ENV_SHAPE, 8'h05, 1'b1));
    for (int i = 0; i < 6; i++) sq.push_back(mk(1'b1, 1'b0, 4'd0, 8'h00, 1'b0));
    foreach (sq[i]) begin
      drive(sq[i]);
      e = exp_q.pop_front();
      got = obs();
      checks++;
      if (got !== e || (sq[i].r && {step, null_period, restart, ctrl} !== 7'b0100000)) begin
        errors++;
        $display("FAIL reset_mid[%0d]: got %h expected %h", i, got, e);
      end
    end
  endtask

  initial begin
    bus_if.wr = 1'b0;
    bus_if.addr = 4'd0;
    bus_if.din = 8'h00;
    #1;
    test_reset();
    test_idle();
    test_period();
    test_back_to_back();
    test_lower_period();
    test_max_period();
    test_reset_mid();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #300000;
    $display("FAIL watchdog: simulation did not complete within time limit");
    $fatal(1);
  end

endmodule

// File: doc/jt49_env_div.md
JT49_ENV_DIV -- requirements
Module: jt49_env_div

Interface
REQ-001 The module SHALL have parameter PRESCALE, default 8, giving the number of cen pulses per envelope tick; legal values are powers of two from 2 to 16.
REQ-002 Port: clk  input  1  system clock; every flop SHALL sit on its rising edge.
REQ-003 Port: rst  input  1  synchronous, active-high reset.
REQ-004 Port: cen  input  1  chip clock enable, one clk cycle wide.
REQ-005 Port: wr  input  1  register write strobe, one clk cycle wide, honoured regardless of cen.
REQ-006 Port: addr  input  4  register address; only 11, 12 and 13 SHALL be decoded.
REQ-007 Port: din  input  8  write data.
REQ-008 Port: step  output  1  envelope step square wave, feeding the envelope generator.
REQ-009 Port: null_period  output  1  high while the 16-bit period register equals 0.
REQ-010 Port: restart  output  1  one-clk pulse following a write to shape register 13.
REQ-011 Port: ctrl  output  4  envelope shape bits {CONT, ATT, ALT, HOLD}.

Function
REQ-012 A write to addr 11 SHALL load period[7:0]; a write to addr 12 SHALL load period[15:8]; a write to addr 13 SHALL load ctrl from din[3:0], and din[7:4] SHALL be ignored.
REQ-013 Register writes SHALL take effect on the clk edge where wr=1; the outputs SHALL reflect the new values from the following cycle.
REQ-014 restart SHALL be high for exactly one clk cycle, the cycle after each addr-13 write, including writes of an unchanged value.
REQ-015 Back-to-back addr-13 writes SHALL produce back-to-back restart pulses.
REQ-016 null_period SHALL be registered and equal (period==0), one clk after any period write.
REQ-017 The prescaler SHALL be a log2(PRESCALE)-bit counter that increments on each cen; it SHALL emit an internal tick on the cen where it wraps from PRESCALE-1 to 0.
REQ-018 The period counter cnt SHALL be 16 bits and SHALL advance only on tick.
REQ-019 On a tick, if cnt+1 >= period, the block SHALL set cnt to 0 and toggle step; otherwise it SHALL increment cnt.
REQ-020 The comparison in REQ-019 SHALL use 17-bit arithmetic so that period=0xFFFF does not wrap.
REQ-021 While period==0, step and cnt SHALL hold their values; null_period alone drives the generator.
REQ-022 With period=P>=1, step SHALL toggle every P ticks (rising edge every 2*P*PRESCALE cen pulses); P=1 SHALL toggle on every tick.
REQ-023 A period write that lowers period to <= cnt SHALL cause a wrap and toggle on the next tick, with no counter wrap-around through 0xFFFF.
REQ-024 The cycle after an addr-13 write SHALL clear cnt, the prescaler and step to 0.
REQ-025 If a tick coincides with the REQ-024 clear, the clear SHALL win.
REQ-026 A period write SHALL NOT clear cnt or the prescaler.
REQ-027 A write coinciding with a cen SHALL both update the register and advance the prescaler in that same cycle.

Reset
REQ-028 While rst=1 at a clk edge: period=0, ctrl=0, cnt=0, prescaler=0, step=0, restart=0, null_period=1.
REQ-029 A reset asserted mid-count SHALL take effect on the next edge, with no pending restart surviving the reset.
REQ-030 Reset SHALL take priority over wr and cen.

Structure
REQ-031 The shared package jt49_pkg SHALL hold the address constants ENV_PER_LO=11, ENV_PER_HI=12, ENV_SHAPE=13 and the ctrl bit indices.
REQ-032 The block SHALL contain one sub-module, jt49_env_cnt, holding the prescaler, the 16-bit counter and the step toggle; register decode and the restart pulse stay in the top level.
REQ-033 All outputs SHALL be registered, with no combinational path from inputs to outputs.

Verification
REQ-034 Reset, then idle with cen every 4th clk: null_period=1, step=0, restart=0 and ctrl=0 throughout.
REQ-035 Write addr11=0x03, addr12=0x00, PRESCALE=8, cen continuous: step toggles every 24 cen; the first rising edge comes 24 cen after the write, then every 48.
REQ-036 Write addr13=0x0E twice on consecutive clks: ctrl=0xE, two consecutive one-clk restart pulses, and step and cnt cleared.
REQ-037 With period=0x0100 and cnt at 0x80, write addr11=0x10 and addr12=0x00: step toggles on the next tick, then every 0x10 ticks.
REQ-038 Write period=0xFFFF and force cnt near 0xFFFE: a single toggle at wrap and no spurious toggle. Then write period=0: null_period=1 one clk later and step frozen.
REQ-039 Assert rst mid-count with an addr-13 write in the same cycle: all outputs match the REQ-028 values, and no restart pulse follows.
